// File: rtl/lc3_display_tx.sv
// LC-3 display output path: holds DDR/DSR and shifts the low byte of each
// accepted DDR write out as an 8N1 UART frame on TX.
module lc3_display_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LD_DDR,
  input  logic [15:0] BUS_IN,
  output logic [15:0] DSR_OUT,
  output logic [15:0] DDR_OUT,
  output logic        TX,
  output logic        TX_BUSY
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state = IDLE;
  logic [CW-1:0] cnt   = '0;
  logic [2:0]    idx   = '0;
  logic [15:0]   ddr   = '0;
  logic          ready = 1'b1;
  logic          tx    = 1'b1;
  logic          bit_end;
  logic [7:0]    data_byte;

  assign bit_end   = (cnt == LAST);
  assign data_byte = ddr[7:0];

  // TX is loaded one edge ahead so the line changes in lockstep with the state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      ddr   <= '0;
      ready <= 1'b1;
      tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (LD_DDR) begin
            ddr   <= BUS_IN;
            ready <= 1'b0;
            cnt   <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            tx    <= data_byte[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
              tx  <= data_byte[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign DSR_OUT = {ready, 15'b0};
  assign DDR_OUT = ddr;
  assign TX      = tx;
  assign TX_BUSY = ~ready;

endmodule

// File: tb/tb_lc3_display_tx.sv
// Bench for lc3_display_tx: a frame-timing model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_lc3_display_tx;

  localparam int N = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld    = 1'b0;
  logic [15:0] bus   = 16'h0000;
  logic [15:0] dsr;
  logic [15:0] ddr;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;

  lc3_display_tx #(.CLKS_PER_BIT(N)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .LD_DDR  (ld),
    .BUS_IN  (bus),
    .DSR_OUT (dsr),
    .DDR_OUT (ddr),
    .TX      (tx),
    .TX_BUSY (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge so the next rising edge sees them stable.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] b);
    @(negedge clk);
    rst_n = r;
    ld    = l;
    bus   = b;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0000);
  endtask

  // Model: m_t is the cycle number within the frame, 0 being the first TX=0 cycle.
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_ddr   = 16'h0000;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_t     = 0;
      m_ddr   = 16'h0000;
    end else if (!m_busy) begin
      if (ld) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_ddr  = bus;
      end
    end else begin
      m_t++;
      if (m_t == 10 * N) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int   slot;
      logic exp_tx;
      slot = m_t / N;
      if (!m_busy)        exp_tx = 1'b1;
      else if (slot == 0) exp_tx = 1'b0;
      else if (slot <= 8) exp_tx = m_ddr[slot-1];
      else                exp_tx = 1'b1;
      checkOutput("model_dsr",  dsr,          m_busy ? 16'h0000 : 16'h8000);
      checkOutput("model_ddr",  ddr,          m_ddr);
      checkOutput("model_tx",   {15'b0, tx},   {15'b0, exp_tx});
      checkOutput("model_busy", {15'b0, busy}, {15'b0, m_busy});
    end
  end

  initial begin
    logic [9:0] a_pat;
    logic [9:0] u_pat;
    a_pat = 10'b1010000010;
    u_pat = 10'b1010101010;

    // Reset then idle
    applyStimulus(1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000);
      if (i % 5 == 0) begin
        checkOutput("idle_dsr", dsr, 16'h8000);
        checkOutput("idle_ddr", ddr, 16'h0000);
        checkOutput("idle_tx",  {15'b0, tx}, 16'h0001);
      end
    end

    // Single character 'A'
    applyStimulus(1'b1, 1'b1, 16'h0041);
    for (int k = 0; k < 10 * N; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000);
      if (k == 0) begin
        checkOutput("a_dsr_busy", dsr, 16'h0000);
        checkOutput("a_ddr",      ddr, 16'h0041);
      end
      if (k % N == 0 || k % N == N - 1)
        checkOutput("a_tx_bit", {15'b0, tx}, {15'b0, a_pat[k / N]});
    end
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("a_dsr_ready_at_160", dsr, 16'h8000);

    // Write while busy
    applyStimulus(1'b1, 1'b1, 16'h0041);
    for (int k = 0; k < 10 * N + 20; k++) begin
      applyStimulus(1'b1, k == 50, 16'h005A);
      if (k == 60)  checkOutput("busy_ddr_kept", ddr, 16'h0041);
      if (k == 7 * N + 8) checkOutput("busy_tx_bit6", {15'b0, tx}, 16'h0001);
      if (k == 10 * N + 5) begin
        checkOutput("busy_no_second_tx",  {15'b0, tx}, 16'h0001);
        checkOutput("busy_no_second_dsr", dsr, 16'h8000);
      end
    end

    // Back-to-back: high byte ignored, next write lands on the first ready cycle
    applyStimulus(1'b1, 1'b1, 16'hFF55);
    for (int k = 0; k < 10 * N; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000);
      if (k % N == N / 2)
        checkOutput("b2b_tx_bit", {15'b0, tx}, {15'b0, u_pat[k / N]});
    end
    applyStimulus(1'b1, 1'b1, 16'h0033);
    checkOutput("b2b_ready_dsr", dsr, 16'h8000);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("b2b_second_start", {15'b0, tx}, 16'h0000);
    checkOutput("b2b_second_ddr",   ddr, 16'h0033);
    idleCycles(10 * N + 4);

    // LD_DDR held across several edges: only the first is taken
    applyStimulus(1'b1, 1'b1, 16'h0012);
    applyStimulus(1'b1, 1'b1, 16'h0034);
    applyStimulus(1'b1, 1'b1, 16'h0056);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("hold_ddr_first", ddr, 16'h0012);
    checkOutput("hold_dsr_busy",  dsr, 16'h0000);
    idleCycles(10 * N + 4);

    // Reset mid-frame
    applyStimulus(1'b1, 1'b1, 16'h0000);
    idleCycles(40);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("midrst_tx",  {15'b0, tx}, 16'h0001);
    checkOutput("midrst_dsr", dsr, 16'h8000);
    checkOutput("midrst_ddr", ddr, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h0031);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("midrst_new_ddr",   ddr, 16'h0031);
    checkOutput("midrst_new_start", {15'b0, tx}, 16'h0000);
    idleCycles(10 * N);
    checkOutput("midrst_new_ready", dsr, 16'h8000);

    // Reset and write in the same cycle: reset wins
    applyStimulus(1'b0, 1'b1, 16'h0041);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("coll_ddr", ddr, 16'h0000);
    checkOutput("coll_dsr", dsr, 16'h8000);
    checkOutput("coll_tx",  {15'b0, tx}, 16'h0001);
    idleCycles(5);
    checkOutput("coll_tx_later", {15'b0, tx}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
